// File: rtl/pll_sup_pkg.sv
// ----------------------------------------------------------------------------
// pll_sup_pkg
// Shared types and constants for the PLL lock supervisor.
//   pll_state_t : per-PLL supervisor FSM state
//   LOL_W       : width of each per-PLL loss-of-lock counter
//   RETRY_W     : width of the retry counter (MAX_RETRY up to 15)
// ----------------------------------------------------------------------------
package pll_sup_pkg;

   typedef enum logic [2:0] {
      ST_RST,
      ST_WAIT,
      ST_STABLE,
      ST_LOCKED,
      ST_FAULT
   } pll_state_t;

   localparam int unsigned LOL_W   = 8;
   localparam int unsigned RETRY_W = 4;

endpackage

// File: rtl/pll_lock_fsm.sv
// ----------------------------------------------------------------------------
// pll_lock_fsm
// Supervisor for one PLL: synchronises its raw lock flag, drives its reset,
// qualifies lock, retries on timeout and latches a fault after MAX_RETRY
// failed attempts.
// Optional feature macro: PLL_LOL_COUNT_EN (loss-of-lock counter; tied to 0
// when undefined).
// Ports:
//   refclk    in  free-running reference clock
//   rst_n     in  asynchronous active-low reset
//   locked_in in  raw PLL locked flag, asynchronous to refclk
//   clr_fault in  1-cycle pulse: clears retries, restarts a faulted PLL
//   pll_rst   out active-high PLL reset (registered)
//   pll_ok    out PLL is in LOCKED (registered)
//   fault     out retries exhausted (registered)
//   lol_count out saturating loss-of-lock counter
// ----------------------------------------------------------------------------
module pll_lock_fsm
   import pll_sup_pkg::*;
#(
   parameter int unsigned PLL_RST_CYC      = 16,
   parameter int unsigned LOCK_TIMEOUT_CYC = 50000,
   parameter int unsigned LOCK_STABLE_CYC  = 1024,
   parameter int unsigned MAX_RETRY        = 3,
   parameter int unsigned CNT_W            = 16
) (
   input  logic             refclk,
   input  logic             rst_n,
   input  logic             locked_in,
   input  logic             clr_fault,
   output logic             pll_rst,
   output logic             pll_ok,
   output logic             fault,
   output logic [LOL_W-1:0] lol_count
);

   localparam logic [CNT_W-1:0]   RST_LAST     = CNT_W'(PLL_RST_CYC - 1);
   localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYC - 1);
   localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(LOCK_STABLE_CYC - 1);
   localparam logic [RETRY_W-1:0] RETRY_MAX    = RETRY_W'(MAX_RETRY);

   logic               sync1_q, sync2_q;
   pll_state_t         state_q, state_d;
   logic [CNT_W-1:0]   timer_q, timer_d;
   logic [RETRY_W-1:0] retry_q, retry_d;
   logic               lol_event;

   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
      end else begin
         sync1_q <= locked_in;
         sync2_q <= sync1_q;
      end
   end

   // One timer serves all states: reset hold, lock timeout and stable count.
   always_comb begin
      state_d   = state_q;
      timer_d   = timer_q + 1'b1;
      retry_d   = retry_q;
      lol_event = 1'b0;
      case (state_q)
         ST_RST: begin
            if (timer_q == RST_LAST) begin
               state_d = ST_WAIT;
               timer_d = '0;
            end
         end
         ST_WAIT: begin
            if (sync2_q) begin
               // The cycle that saw lock counts as the first stable cycle.
               state_d = ST_STABLE;
               timer_d = CNT_W'(1);
            end else if (timer_q == TIMEOUT_LAST) begin
               timer_d = '0;
               retry_d = retry_q + 1'b1;
               state_d = (retry_d == RETRY_MAX) ? ST_FAULT : ST_RST;
            end
         end
         ST_STABLE: begin
            if (!sync2_q) begin
               state_d = ST_WAIT;
               timer_d = '0;
            end else if (timer_q >= STABLE_LAST) begin
               state_d = ST_LOCKED;
               timer_d = '0;
               retry_d = '0;
            end
         end
         ST_LOCKED: begin
            timer_d = '0;
            if (!sync2_q) begin
               state_d   = ST_RST;
               lol_event = 1'b1;
            end
         end
         ST_FAULT: begin
            timer_d = '0;
            if (clr_fault) begin
               state_d = ST_RST;
            end
         end
         default: begin
            state_d = ST_RST;
            timer_d = '0;
         end
      endcase
      if (clr_fault) begin
         retry_d = '0;
      end
   end

   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_RST;
         timer_q <= '0;
         retry_q <= '0;
         pll_rst <= 1'b1;
         pll_ok  <= 1'b0;
         fault   <= 1'b0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         retry_q <= retry_d;
         pll_rst <= (state_d == ST_RST) || (state_d == ST_FAULT);
         pll_ok  <= (state_d == ST_LOCKED);
         fault   <= (state_d == ST_FAULT);
      end
   end

`ifdef PLL_LOL_COUNT_EN
   logic [LOL_W-1:0] lol_q;

   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
         lol_q <= '0;
      end else if (lol_event && (lol_q != '1)) begin
         lol_q <= lol_q + 1'b1;
      end
   end

   assign lol_count = lol_q;
`else
   logic unused_lol_event;
   assign unused_lol_event = lol_event;
   assign lol_count        = '0;
`endif

endmodule

// File: rtl/pll_lock_supervisor.sv
// ----------------------------------------------------------------------------
// pll_lock_supervisor
// Supervises NUM_PLL PLLs from the refclk domain and releases the downstream
// system reset only while every PLL holds lock.
// Optional feature macro: PLL_LOL_COUNT_EN (per-PLL loss-of-lock counters).
// Ports:
//   refclk    in  free-running reference clock
//   rst_n     in  asynchronous active-low reset
//   locked_in in  raw PLL locked flags (asynchronous)
//   clr_fault in  1-cycle pulse: clear faults/retries, restart faulted PLLs
//   pll_rst   out active-high reset per PLL
//   pll_ok    out PLL i is locked
//   fault     out PLL i exhausted its retries
//   sys_rst_n out active-low downstream reset
//   lol_count out per-PLL saturating loss-of-lock counters, PLL0 in [7:0]
// ----------------------------------------------------------------------------
module pll_lock_supervisor
   import pll_sup_pkg::*;
#(
   parameter int unsigned NUM_PLL          = 2,
   parameter int unsigned PLL_RST_CYC      = 16,
   parameter int unsigned LOCK_TIMEOUT_CYC = 50000,
   parameter int unsigned LOCK_STABLE_CYC  = 1024,
   parameter int unsigned MAX_RETRY        = 3,
   parameter int unsigned CNT_W            = 16
) (
   input  logic                     refclk,
   input  logic                     rst_n,
   input  logic [NUM_PLL-1:0]       locked_in,
   input  logic                     clr_fault,
   output logic [NUM_PLL-1:0]       pll_rst,
   output logic [NUM_PLL-1:0]       pll_ok,
   output logic [NUM_PLL-1:0]       fault,
   output logic                     sys_rst_n,
   output logic [LOL_W*NUM_PLL-1:0] lol_count
);

   for (genvar i = 0; i < NUM_PLL; i++) begin : g_pll
      pll_lock_fsm #(
         .PLL_RST_CYC      (PLL_RST_CYC),
         .LOCK_TIMEOUT_CYC (LOCK_TIMEOUT_CYC),
         .LOCK_STABLE_CYC  (LOCK_STABLE_CYC),
         .MAX_RETRY        (MAX_RETRY),
         .CNT_W            (CNT_W)
      ) u_fsm (
         .refclk    (refclk),
         .rst_n     (rst_n),
         .locked_in (locked_in[i]),
         .clr_fault (clr_fault),
         .pll_rst   (pll_rst[i]),
         .pll_ok    (pll_ok[i]),
         .fault     (fault[i]),
         .lol_count (lol_count[i*LOL_W +: LOL_W])
      );
   end

   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
         sys_rst_n <= 1'b0;
      end else begin
         sys_rst_n <= &pll_ok;
      end
   end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// ----------------------------------------------------------------------------
// tb_pll_lock_supervisor
// Directed bench for pll_lock_supervisor with small timing parameters.
// Cycle k means the interval just after the k-th rising edge following reset
// release; cycle 0 is the interval between release and the first edge.
// Lock-loss counter expectations follow PLL_LOL_COUNT_EN.
// ----------------------------------------------------------------------------
module tb_pll_lock_supervisor;

   localparam int unsigned NUM_PLL = 2;

`ifdef PLL_LOL_COUNT_EN
   localparam bit LOL_EN = 1'b1;
`else
   localparam bit LOL_EN = 1'b0;
`endif

   logic                 refclk;
   logic                 rst_n;
   logic [NUM_PLL-1:0]   locked_in;
   logic                 clr_fault;
   logic [NUM_PLL-1:0]   pll_rst;
   logic [NUM_PLL-1:0]   pll_ok;
   logic [NUM_PLL-1:0]   fault;
   logic                 sys_rst_n;
   logic [8*NUM_PLL-1:0] lol_count;

   pll_lock_supervisor #(
      .NUM_PLL          (NUM_PLL),
      .PLL_RST_CYC      (4),
      .LOCK_TIMEOUT_CYC (32),
      .LOCK_STABLE_CYC  (8),
      .MAX_RETRY        (2),
      .CNT_W            (16)
   ) dut (
      .refclk    (refclk),
      .rst_n     (rst_n),
      .locked_in (locked_in),
      .clr_fault (clr_fault),
      .pll_rst   (pll_rst),
      .pll_ok    (pll_ok),
      .fault     (fault),
      .sys_rst_n (sys_rst_n),
      .lol_count (lol_count)
   );

   initial refclk = 1'b0;
   always #5 refclk = ~refclk;

   int n_chk  = 0;
   int n_fail = 0;
   int cyc    = 0;

   typedef struct {
      bit         do_rst;  // apply a fresh reset before this row
      int         at;      // cycle at which outputs are compared
      logic [1:0] e_rst;
      logic [1:0] e_ok;
      logic [1:0] e_fault;
      logic       e_sys;
      logic [1:0] lck;     // locked_in applied after the compare
      logic       clr;     // clr_fault pulse applied after the compare
   } vec_t;

   vec_t tbl[21];

   task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Advance one cycle, sampling 1 time unit after the edge; clr_fault is a pulse.
   task automatic tick();
      @(posedge refclk);
      #1;
      cyc++;
      clr_fault = 1'b0;
   endtask

   task automatic advance_to(input int at);
      while (cyc < at) tick();
   endtask

   task automatic do_reset();
      locked_in = '0;
      clr_fault = 1'b0;
      rst_n     = 1'b0;
      repeat (2) @(posedge refclk);
      #1;
      rst_n = 1'b1;
      cyc   = 0;
   endtask

   task automatic check_outs(input string nm, input logic [1:0] er, input logic [1:0] eo,
                             input logic [1:0] ef, input logic es);
      check({nm, "_pll_rst"}, 16'(pll_rst), 16'(er));
      check({nm, "_pll_ok"}, 16'(pll_ok), 16'(eo));
      check({nm, "_fault"}, 16'(fault), 16'(ef));
      check({nm, "_sys_rst_n"}, 16'(sys_rst_n), 16'(es));
   endtask

   task automatic run_rows(input int lo, input int hi);
      for (int i = lo; i <= hi; i++) begin
         if (tbl[i].do_rst) do_reset();
         advance_to(tbl[i].at);
         check_outs($sformatf("row%0d", i), tbl[i].e_rst, tbl[i].e_ok, tbl[i].e_fault,
                    tbl[i].e_sys);
         locked_in = tbl[i].lck;
         clr_fault = tbl[i].clr;
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int   w;
      logic [7:0] exp_lol;

      // Power-up lock: both PLLs lock together.
      tbl[0]  = '{1, 0,  2'b11, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0};
      tbl[1]  = '{0, 3,  2'b11, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0};
      tbl[2]  = '{0, 4,  2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0};
      tbl[3]  = '{0, 6,  2'b00, 2'b00, 2'b00, 1'b0, 2'b11, 1'b0};
      tbl[4]  = '{0, 15, 2'b00, 2'b00, 2'b00, 1'b0, 2'b11, 1'b0};
      tbl[5]  = '{0, 16, 2'b00, 2'b11, 2'b00, 1'b0, 2'b11, 1'b0};
      tbl[6]  = '{0, 17, 2'b00, 2'b11, 2'b00, 1'b1, 2'b11, 1'b0};
      // PLL0 never locks: two timed-out attempts, fault, then clr_fault and relock.
      tbl[7]  = '{1, 0,  2'b11, 2'b00, 2'b00, 1'b0, 2'b10, 1'b0};
      tbl[8]  = '{0, 12, 2'b00, 2'b10, 2'b00, 1'b0, 2'b10, 1'b0};
      tbl[9]  = '{0, 35, 2'b00, 2'b10, 2'b00, 1'b0, 2'b10, 1'b0};
      tbl[10] = '{0, 36, 2'b01, 2'b10, 2'b00, 1'b0, 2'b10, 1'b0};
      tbl[11] = '{0, 40, 2'b00, 2'b10, 2'b00, 1'b0, 2'b10, 1'b0};
      tbl[12] = '{0, 71, 2'b00, 2'b10, 2'b00, 1'b0, 2'b10, 1'b0};
      tbl[13] = '{0, 72, 2'b01, 2'b10, 2'b01, 1'b0, 2'b10, 1'b0};
      tbl[14] = '{0, 80, 2'b01, 2'b10, 2'b01, 1'b0, 2'b11, 1'b1};
      tbl[15] = '{0, 81, 2'b01, 2'b10, 2'b00, 1'b0, 2'b11, 1'b0};
      tbl[16] = '{0, 84, 2'b01, 2'b10, 2'b00, 1'b0, 2'b11, 1'b0};
      tbl[17] = '{0, 85, 2'b00, 2'b10, 2'b00, 1'b0, 2'b11, 1'b0};
      tbl[18] = '{0, 92, 2'b00, 2'b10, 2'b00, 1'b0, 2'b11, 1'b0};
      tbl[19] = '{0, 93, 2'b00, 2'b11, 2'b00, 1'b0, 2'b11, 1'b0};
      tbl[20] = '{0, 94, 2'b00, 2'b11, 2'b00, 1'b1, 2'b11, 1'b0};

      rst_n     = 1'b0;
      locked_in = '0;
      clr_fault = 1'b0;

      run_rows(0, 0);
      check("reset_lol_count", lol_count, 16'h0000);
      run_rows(1, 6);

      // PLL1 drops lock for one cycle while both are locked.
      advance_to(20);
      locked_in = 2'b01;
      tick();
      locked_in = 2'b11;
      advance_to(22);
      check_outs("lol_c22", 2'b00, 2'b11, 2'b00, 1'b1);
      advance_to(23);
      check_outs("lol_c23", 2'b10, 2'b01, 2'b00, 1'b1);
      advance_to(24);
      check_outs("lol_c24", 2'b10, 2'b01, 2'b00, 1'b0);
      check("lol_count_pll1", lol_count, {(LOL_EN ? 8'd1 : 8'd0), 8'd0});
      advance_to(26);
      check("lol_c26_pll_rst", 16'(pll_rst), 16'h0002);
      advance_to(27);
      check("lol_c27_pll_rst", 16'(pll_rst), 16'h0000);
      advance_to(34);
      check("lol_c34_pll_ok", 16'(pll_ok), 16'h0001);
      advance_to(35);
      check("lol_c35_pll_ok", 16'(pll_ok), 16'h0003);
      advance_to(36);
      check("lol_c36_sys_rst_n", 16'(sys_rst_n), 16'h0001);

      // Glitch at stable count 5 sends both PLLs back to WAIT.
      do_reset();
      locked_in = 2'b11;
      advance_to(7);
      locked_in = 2'b00;
      tick();
      locked_in = 2'b11;
      advance_to(10);
      check_outs("glitch_c10", 2'b00, 2'b00, 2'b00, 1'b0);
      advance_to(12);
      check("glitch_c12_pll_ok", 16'(pll_ok), 16'h0000);
      advance_to(17);
      check("glitch_c17_pll_ok", 16'(pll_ok), 16'h0000);
      advance_to(18);
      check("glitch_c18_pll_ok", 16'(pll_ok), 16'h0003);

      run_rows(7, 20);

      // Asynchronous reset during STABLE, then relock from scratch.
      do_reset();
      locked_in = 2'b11;
      advance_to(7);
      check("stable_pre_pll_rst", 16'(pll_rst), 16'h0000);
      rst_n = 1'b0;
      #1;
      check_outs("rst_in_stable", 2'b11, 2'b00, 2'b00, 1'b0);
      do_reset();
      locked_in = 2'b11;
      advance_to(11);
      check("relock1_c11_pll_ok", 16'(pll_ok), 16'h0000);
      advance_to(12);
      check("relock1_c12_pll_ok", 16'(pll_ok), 16'h0003);
      advance_to(13);
      check("relock1_c13_sys_rst_n", 16'(sys_rst_n), 16'h0001);

      // Asynchronous reset during FAULT.
      do_reset();
      advance_to(72);
      check("fault_pre", 16'(fault), 16'h0003);
      rst_n = 1'b0;
      #1;
      check_outs("rst_in_fault", 2'b11, 2'b00, 2'b00, 1'b0);
      do_reset();
      locked_in = 2'b11;
      advance_to(12);
      check("relock2_c12_pll_ok", 16'(pll_ok), 16'h0003);

      // 300 forced lock losses on PLL0.
      do_reset();
      locked_in = 2'b11;
      for (int i = 1; i <= 301; i++) begin
         w = 0;
         while (!pll_ok[0] && w < 40) begin
            tick();
            w++;
         end
         check($sformatf("sat_relock%0d", i), 16'(pll_ok[0]), 16'h0001);
         if (!pll_ok[0]) break;
         if (i == 201 || i == 256 || i == 301) begin
            exp_lol = LOL_EN ? ((i - 1 > 255) ? 8'd255 : 8'(i - 1)) : 8'd0;
            check($sformatf("sat_lol_after_%0d", i - 1), lol_count, {8'd0, exp_lol});
         end
         if (i == 301) break;
         locked_in[0] = 1'b0;
         tick();
         locked_in[0] = 1'b1;
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
